// File: rtl/coreriscv_axi4_tl_pkg.sv
// TileLink field widths, message type encodings and arbiter state type shared by
// the round-robin acquire arbiter and its optional output skid buffer.
package coreriscv_axi4_tl_pkg;

  localparam int ADDR_BLOCK_W = 26;
  localparam int ADDR_BEAT_W  = 3;
  localparam int UNION_W      = 12;
  localparam int DATA_W       = 64;
  localparam int A_TYPE_W     = 3;
  localparam int G_TYPE_W     = 4;

  // Built-in acquire types
  localparam logic [A_TYPE_W-1:0] A_GET          = 3'd0;
  localparam logic [A_TYPE_W-1:0] A_GET_BLOCK    = 3'd1;
  localparam logic [A_TYPE_W-1:0] A_PUT          = 3'd2;
  localparam logic [A_TYPE_W-1:0] A_PUT_BLOCK    = 3'd3;
  localparam logic [A_TYPE_W-1:0] A_PUT_ATOMIC   = 3'd4;

  // Built-in grant types
  localparam logic [G_TYPE_W-1:0] G_VOLUNTARY_ACK = 4'd0;
  localparam logic [G_TYPE_W-1:0] G_PREFETCH_ACK  = 4'd1;
  localparam logic [G_TYPE_W-1:0] G_PUT_ACK       = 4'd2;
  localparam logic [G_TYPE_W-1:0] G_GET_DATA_BEAT = 4'd3;
  localparam logic [G_TYPE_W-1:0] G_GET_DATA_BLK  = 4'd4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Only a built-in putBlock carries more than one beat upstream.
  function automatic logic is_multibeat(input logic builtin, input logic [A_TYPE_W-1:0] a_type);
    return builtin && (a_type == A_PUT_BLOCK);
  endfunction

endpackage

// File: rtl/coreriscv_axi4_tl_skid.sv
// Two-entry skid buffer: registered output, full throughput, ready = not full.
// Handshake: a word moves on any port in a cycle where valid && ready are both 1.
module coreriscv_axi4_tl_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   count;
  logic         push, pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/coreriscv_axi4_tl_rr_arbiter.sv
// Round-robin TileLink acquire arbiter with putBlock locking and grant routing by id.
// Define CORERISCV_AXI4_ARB_OUTREG_EN to register the manager acquire port through a skid buffer.
module coreriscv_axi4_tl_rr_arbiter
  import coreriscv_axi4_tl_pkg::*;
#(
  parameter int  N_CLIENTS = 2,
  parameter int  ID_BITS   = 2,
  parameter int  BEATS     = 8,
  localparam int CLG       = $clog2(N_CLIENTS),
  localparam int OID       = ID_BITS + CLG,
  localparam int BW        = $clog2(BEATS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_CLIENTS-1:0]              io_in_acquire_valid,
  output logic [N_CLIENTS-1:0]              io_in_acquire_ready,
  input  logic [N_CLIENTS*ADDR_BLOCK_W-1:0] io_in_acquire_addr_block,
  input  logic [N_CLIENTS*ID_BITS-1:0]      io_in_acquire_client_xact_id,
  input  logic [N_CLIENTS*ADDR_BEAT_W-1:0]  io_in_acquire_addr_beat,
  input  logic [N_CLIENTS-1:0]              io_in_acquire_is_builtin_type,
  input  logic [N_CLIENTS*A_TYPE_W-1:0]     io_in_acquire_a_type,
  input  logic [N_CLIENTS*UNION_W-1:0]      io_in_acquire_union,
  input  logic [N_CLIENTS*DATA_W-1:0]       io_in_acquire_data,
  output logic [N_CLIENTS-1:0]              io_in_grant_valid,
  input  logic [N_CLIENTS-1:0]              io_in_grant_ready,
  output logic [ADDR_BEAT_W-1:0]            io_in_grant_addr_beat,
  output logic [ID_BITS-1:0]                io_in_grant_client_xact_id,
  output logic                              io_in_grant_manager_xact_id,
  output logic                              io_in_grant_is_builtin_type,
  output logic [G_TYPE_W-1:0]               io_in_grant_g_type,
  output logic [DATA_W-1:0]                 io_in_grant_data,
  output logic                              io_out_acquire_valid,
  input  logic                              io_out_acquire_ready,
  output logic [ADDR_BLOCK_W-1:0]           io_out_acquire_addr_block,
  output logic [OID-1:0]                    io_out_acquire_client_xact_id,
  output logic [ADDR_BEAT_W-1:0]            io_out_acquire_addr_beat,
  output logic                              io_out_acquire_is_builtin_type,
  output logic [A_TYPE_W-1:0]               io_out_acquire_a_type,
  output logic [UNION_W-1:0]                io_out_acquire_union,
  output logic [DATA_W-1:0]                 io_out_acquire_data,
  input  logic                              io_out_grant_valid,
  output logic                              io_out_grant_ready,
  input  logic [ADDR_BEAT_W-1:0]            io_out_grant_addr_beat,
  input  logic [OID-1:0]                    io_out_grant_client_xact_id,
  input  logic                              io_out_grant_manager_xact_id,
  input  logic                              io_out_grant_is_builtin_type,
  input  logic [G_TYPE_W-1:0]               io_out_grant_g_type,
  input  logic [DATA_W-1:0]                 io_out_grant_data,
  output logic                              dbg_locked,
  output logic [CLG-1:0]                    dbg_ptr,
  output logic [CLG-1:0]                    dbg_owner,
  output logic [BW-1:0]                     dbg_beat
);

  localparam int PW = ADDR_BLOCK_W + OID + ADDR_BEAT_W + 1 + A_TYPE_W + UNION_W + DATA_W;

  arb_state_t     state, state_n;
  logic [CLG-1:0] ptr, ptr_n, owner, owner_n, rr_sel, sel, next_ptr;
  logic [BW-1:0]  beat, beat_n;
  logic           rr_found, locked, sel_valid, arb_valid, down_ready, fire, is_put;
  logic [PW-1:0]  arb_payload, out_payload;
  logic [CLG-1:0] dest;
  int             sel_i;

  // First valid client at or after ptr, wrapping.
  always_comb begin : rr_search
    int idx;
    idx      = 0;
    rr_sel   = ptr;
    rr_found = 1'b0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      idx = (int'(ptr) + k) % N_CLIENTS;
      if (!rr_found && io_in_acquire_valid[idx]) begin
        rr_found = 1'b1;
        rr_sel   = CLG'(idx);
      end
    end
  end

  assign locked    = (state == ST_LOCKED);
  assign sel       = locked ? owner : rr_sel;
  assign sel_i     = int'(sel);
  // While locked only the owner may send; a stalled owner stalls everyone.
  assign sel_valid = locked ? io_in_acquire_valid[owner] : rr_found;
  assign arb_valid = reset && sel_valid;
  assign fire      = arb_valid && down_ready;
  assign is_put    = is_multibeat(io_in_acquire_is_builtin_type[sel],
                                  io_in_acquire_a_type[sel_i*A_TYPE_W +: A_TYPE_W]);
  assign next_ptr  = (sel_i == N_CLIENTS - 1) ? '0 : sel + 1'b1;

  always_comb begin
    io_in_acquire_ready = '0;
    if (reset) io_in_acquire_ready[sel] = down_ready;
  end

  assign arb_payload = {io_in_acquire_addr_block[sel_i*ADDR_BLOCK_W +: ADDR_BLOCK_W],
                        sel,
                        io_in_acquire_client_xact_id[sel_i*ID_BITS +: ID_BITS],
                        io_in_acquire_addr_beat[sel_i*ADDR_BEAT_W +: ADDR_BEAT_W],
                        io_in_acquire_is_builtin_type[sel],
                        io_in_acquire_a_type[sel_i*A_TYPE_W +: A_TYPE_W],
                        io_in_acquire_union[sel_i*UNION_W +: UNION_W],
                        io_in_acquire_data[sel_i*DATA_W +: DATA_W]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
      owner <= '0;
      beat  <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      beat  <= beat_n;
    end
  end

  // Beat counter ignores client addr_beat; it wraps to 0 on the final putBlock beat.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    beat_n  = beat;
    if (fire) begin
      case (state)
        ST_IDLE: begin
          if (is_put) begin
            state_n = ST_LOCKED;
            owner_n = sel;
            beat_n  = BW'(1);
          end else begin
            ptr_n = next_ptr;
          end
        end
        ST_LOCKED: begin
          beat_n = beat + 1'b1;
          if (beat == BW'(BEATS - 1)) begin
            state_n = ST_IDLE;
            ptr_n   = next_ptr;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

`ifdef CORERISCV_AXI4_ARB_OUTREG_EN
  logic skid_valid;

  coreriscv_axi4_tl_skid #(.W(PW)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (arb_valid),
    .in_ready  (down_ready),
    .in_data   (arb_payload),
    .out_valid (skid_valid),
    .out_ready (io_out_acquire_ready),
    .out_data  (out_payload)
  );

  assign io_out_acquire_valid = reset && skid_valid;
`else
  assign down_ready           = io_out_acquire_ready;
  assign io_out_acquire_valid = arb_valid;
  assign out_payload          = arb_payload;
`endif

  assign {io_out_acquire_addr_block, io_out_acquire_client_xact_id, io_out_acquire_addr_beat,
          io_out_acquire_is_builtin_type, io_out_acquire_a_type, io_out_acquire_union,
          io_out_acquire_data} = out_payload;

  // Grant path: purely combinational, steered by the upper id bits; unknown dests are sunk.
  assign dest = io_out_grant_client_xact_id[OID-1:ID_BITS];

  always_comb begin
    io_in_grant_valid  = '0;
    io_out_grant_ready = 1'b1;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (dest == CLG'(i)) begin
        io_in_grant_valid[i] = io_out_grant_valid;
        io_out_grant_ready   = io_in_grant_ready[i];
      end
    end
  end

  assign io_in_grant_addr_beat       = io_out_grant_addr_beat;
  assign io_in_grant_client_xact_id  = io_out_grant_client_xact_id[ID_BITS-1:0];
  assign io_in_grant_manager_xact_id = io_out_grant_manager_xact_id;
  assign io_in_grant_is_builtin_type = io_out_grant_is_builtin_type;
  assign io_in_grant_g_type          = io_out_grant_g_type;
  assign io_in_grant_data            = io_out_grant_data;

  assign dbg_locked = locked;
  assign dbg_ptr    = ptr;
  assign dbg_owner  = owner;
  assign dbg_beat   = beat;

endmodule
